pipelined_operand_mux: RTL and testbench
========================================

Name: pipelined_operand_mux

Overview:
- Parametrised N-input operand multiplexer with a registered output stage and valid/ready handshake. It is the successor to the fixed 3-input combinational mux.
- Used at ID/EX and EX/MEM boundaries in the pipelined datapath, where forwarded operands must be selected and held across back-pressure and stalls.
- Contains a 2-entry skid buffer (main + skid) so upstream sees a registered ready and no combinational ready path exists.

Parameters:
- NBits, 32, data width of each input and of the output.
- NInputs, 4, number of data inputs; legal range 2..16.
- SelBits, 2, selector width; integrator must set it to at least clog2(NInputs).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- Flush  input  1  synchronous pipeline flush.
- In_Valid  input  1  upstream presents a selection request.
- In_Ready  output  1  block can accept a request this cycle.
- Selector  input  SelBits  index of the input to capture.
- MUX_Data  input  NInputs*NBits  flattened inputs; input k occupies bits [k*NBits +: NBits].
- Out_Valid  output  1  MUX_Output holds a valid operand.
- Out_Ready  input  1  downstream consumes the operand this cycle.
- MUX_Output  output  NBits  selected, registered operand.
- Sel_Error  output  1  sticky flag for an out-of-range selector.

Behaviour:
- Reset (reset=0, asynchronous):
  - Main and skid entries invalid, data 0.
  - Out_Valid=0, MUX_Output=0, In_Ready=1, Sel_Error=0.
  - Reset takes effect mid-transfer; in-flight data is discarded.
- Handshakes:
  - Accept = In_Valid & In_Ready.
  - Transfer out = Out_Valid & Out_Ready.
  - In_Ready = !skid_valid, driven only from a register; no combinational path from Out_Ready.
- Selection:
  - The selected word is MUX_Data[Selector*NBits +: NBits] when Selector < NInputs.
  - When Selector >= NInputs, the selected word is 0 and Sel_Error is set on accept.
  - Selection is evaluated only in an accept cycle; Selector/MUX_Data changes while not accepting have no effect.
- Latency: accepted data appears on MUX_Output with Out_Valid=1 in the next cycle (1-cycle latency) when the main entry is empty or being drained.
- Datapath per rising edge, priority top-down:
  1. Flush=1: main and skid invalidated, MUX_Output=0, Out_Valid=0, In_Ready=1 next cycle. A request presented in the same cycle is dropped, even if In_Valid=1. Sel_Error is NOT cleared by Flush.
  2. Accept while main empty, or main valid with Out_Ready=1 and skid empty: main loads the selected word.
  3. Accept while main valid and Out_Ready=0: skid loads the selected word; In_Ready=0 next cycle.
  4. Out_Ready=1 with skid valid: main takes skid, skid invalidated. No accept is possible in this cycle because In_Ready=0.
  5. Out_Ready=1 with main valid, skid empty and no accept: main invalidated.
- Hold: while Out_Valid=1 and Out_Ready=0, MUX_Output and Out_Valid are stable.
- Full condition: both entries valid. In_Ready=0; upstream must hold its request.
- Ordering: operands leave in acceptance order; no loss and no duplication except by Flush or reset.
- Sel_Error: set on an accept with an out-of-range selector, cleared only by reset. The offending operand is still delivered, as value 0, with Out_Valid=1.

Test Plan:
- Reset then one request: NInputs=4, Selector=2, input2=0xDEADBEEF, In_Valid=1 for one cycle → next cycle Out_Valid=1, MUX_Output=0xDEADBEEF, In_Ready=1.
- Back-pressure: Out_Ready=0; accept A=0x11 then B=0x22 → In_Ready=0 after B, C=0x33 held off. Raise Out_Ready → outputs 0x11, 0x22, then C accepted and output 0x33, in order with no gaps beyond 1 cycle.
- Streaming: In_Valid=1 and Out_Ready=1 continuously for 8 requests with Selector cycling 0..3 → one output per cycle, 1-cycle latency, In_Ready constantly 1.
- Out-of-range: NInputs=3, SelBits=2, Selector=3 → MUX_Output=0 with Out_Valid=1, Sel_Error=1 and still 1 after Flush; 0 only after reset.
- Flush with both entries full plus a simultaneous In_Valid → next cycle Out_Valid=0, MUX_Output=0, In_Ready=1; the dropped request never appears.
- Async reset asserted mid-cycle while full → outputs go to reset values immediately, without waiting for clk; normal operation resumes on the first edge after release.

Source files
------------

// File: rtl/pipelined_operand_mux_if.sv
// pipelined_operand_mux_if: request/response bus of the pipelined operand mux.
// The master drives requests and consumes operands; the mux sits on the slave side.
interface pipelined_operand_mux_if #(
    parameter int NBits   = 32,
    parameter int NInputs = 4,
    parameter int SelBits = 2
);
    logic                       Flush;
    logic                       In_Valid;
    logic                       In_Ready;
    logic [SelBits-1:0]         Selector;
    logic [NInputs*NBits-1:0]   MUX_Data;
    logic                       Out_Valid;
    logic                       Out_Ready;
    logic [NBits-1:0]           MUX_Output;
    logic                       Sel_Error;

    modport master (
        output Flush, In_Valid, Selector, MUX_Data, Out_Ready,
        input  In_Ready, Out_Valid, MUX_Output, Sel_Error
    );
    modport slave (
        input  Flush, In_Valid, Selector, MUX_Data, Out_Ready,
        output In_Ready, Out_Valid, MUX_Output, Sel_Error
    );
endinterface

// File: rtl/pipelined_operand_mux.sv
// pipelined_operand_mux: N-input operand select into a registered main/skid pair.
// In_Ready comes straight from the skid-valid register, so it never depends on Out_Ready.
module pipelined_operand_mux #(
    parameter int NBits   = 32,
    parameter int NInputs = 4,
    parameter int SelBits = 2
) (
    input logic clk,
    input logic reset,
    pipelined_operand_mux_if.slave bus
);
    logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic             sel_err_q, sel_err_d, sel_ok, accept;
    logic [NBits-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d, sel_word;

    always_comb begin
        sel_word = '0;
        sel_ok   = 1'b0;
        for (int k = 0; k < NInputs; k++) begin
            if (int'(bus.Selector) == k) begin
                sel_word = bus.MUX_Data[k*NBits +: NBits];
                sel_ok   = 1'b1;
            end
        end
    end

    assign accept = bus.In_Valid && !skid_valid_q;

    // Priority: flush, load main, load skid, promote skid, drain main.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (bus.Flush) begin
            main_valid_d = 1'b0;
            main_data_d  = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
        end else if (accept && (!main_valid_q || bus.Out_Ready)) begin
            main_valid_d = 1'b1;
            main_data_d  = sel_word;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = sel_word;
        end else if (bus.Out_Ready && skid_valid_q) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (bus.Out_Ready && main_valid_q) begin
            main_valid_d = 1'b0;
        end
        sel_err_d = sel_err_q || (accept && !sel_ok && !bus.Flush);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            sel_err_q    <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign bus.In_Ready   = !skid_valid_q;
    assign bus.Out_Valid  = main_valid_q;
    assign bus.MUX_Output = main_data_q;
    assign bus.Sel_Error  = sel_err_q;
endmodule

// File: tb/tb_pipelined_operand_mux.sv
// tb_pipelined_operand_mux: drives a 4-input and a 3-input mux with identical stimulus
// and compares both against a 2-deep FIFO reference model.
module tb_pipelined_operand_mux;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipelined_operand_mux_if #(.NBits(32), .NInputs(4), .SelBits(2)) b4 ();
    pipelined_operand_mux_if #(.NBits(32), .NInputs(3), .SelBits(2)) b3 ();

    pipelined_operand_mux #(.NBits(32), .NInputs(4), .SelBits(2)) u4 (.clk(clk), .reset(reset), .bus(b4));
    pipelined_operand_mux #(.NBits(32), .NInputs(3), .SelBits(2)) u3 (.clk(clk), .reset(reset), .bus(b3));

    // Reference: per instance, a queue of at most 2 operands, the last shown word and the error flag.
    logic [31:0] mq [2][2];
    int          mc [2];
    logic [31:0] mh [2];
    logic        mz [2];
    logic        me [2];
    int          ni [2] = '{4, 3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0; mh[i] = '0; mz[i] = 1'b1; me[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input logic iv, input logic [1:0] s,
                              input logic [127:0] d, input logic ordy, input logic fl);
        logic rdy;
        rdy = mc[i] < 2;
        if (fl) begin
            mc[i] = 0; mh[i] = '0; mz[i] = 1'b1;
        end else begin
            if (mc[i] > 0 && ordy) begin
                mq[i][0] = mq[i][1];
                mc[i]--;
            end
            if (iv && rdy) begin
                if (int'(s) < ni[i]) mq[i][mc[i]] = d[int'(s)*32 +: 32];
                else begin
                    mq[i][mc[i]] = '0;
                    me[i] = 1'b1;
                end
                mc[i]++;
                mz[i] = 1'b0;
            end
            if (mc[i] > 0) mh[i] = mq[i][0];
        end
    endtask

    task automatic cmp(input string p, input int i, input logic ov, input logic [31:0] mo,
                       input logic ir, input logic se);
        check({p, "_out_valid"}, 32'(ov), 32'(mc[i] > 0));
        if (mc[i] > 0 || mz[i]) check({p, "_mux_output"}, mo, mh[i]);
        check({p, "_in_ready"}, 32'(ir), 32'(mc[i] < 2));
        check({p, "_sel_error"}, 32'(se), 32'(me[i]));
    endtask

    task automatic cmp_all();
        cmp("n4", 0, b4.Out_Valid, b4.MUX_Output, b4.In_Ready, b4.Sel_Error);
        cmp("n3", 1, b3.Out_Valid, b3.MUX_Output, b3.In_Ready, b3.Sel_Error);
    endtask

    task automatic cyc(input logic iv, input logic [1:0] s, input logic [127:0] d,
                       input logic ordy, input logic fl);
        b4.In_Valid = iv;  b3.In_Valid = iv;
        b4.Selector = s;   b3.Selector = s;
        b4.MUX_Data = d;   b3.MUX_Data = d[95:0];
        b4.Out_Ready = ordy; b3.Out_Ready = ordy;
        b4.Flush = fl;     b3.Flush = fl;
        model_step(0, iv, s, d, ordy, fl);
        model_step(1, iv, s, d, ordy, fl);
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    function automatic logic [127:0] rep(input logic [31:0] x);
        return {4{x}};
    endfunction

    initial begin
        logic [127:0] d;
        cyc_init: begin
            b4.In_Valid = 0; b3.In_Valid = 0; b4.Selector = 0; b3.Selector = 0;
            b4.MUX_Data = '0; b3.MUX_Data = '0; b4.Out_Ready = 0; b3.Out_Ready = 0;
            b4.Flush = 0; b3.Flush = 0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp_all();
        check("reset_mux_output", b4.MUX_Output, 32'h0);
        check("reset_in_ready", 32'(b4.In_Ready), 32'h1);
        reset = 1'b1;

        // single request, 1-cycle latency
        cyc(1, 2'd2, {32'h3, 32'hDEADBEEF, 32'h1, 32'h0}, 1, 0);
        check("t1_data", b4.MUX_Output, 32'hDEADBEEF);
        check("t1_valid", 32'(b4.Out_Valid), 32'h1);
        check("t1_ready", 32'(b4.In_Ready), 32'h1);
        cyc(0, 0, '0, 1, 0);

        // back-pressure into the skid entry
        cyc(1, 0, rep(32'h11), 0, 0);
        cyc(1, 0, rep(32'h22), 0, 0);
        check("bp_full_ready", 32'(b4.In_Ready), 32'h0);
        check("bp_hold_a", b4.MUX_Output, 32'h11);
        cyc(1, 0, rep(32'h33), 0, 0);
        check("bp_still_a", b4.MUX_Output, 32'h11);
        cyc(1, 0, rep(32'h33), 1, 0);
        check("bp_out_b", b4.MUX_Output, 32'h22);
        cyc(1, 0, rep(32'h33), 1, 0);
        check("bp_out_c", b4.MUX_Output, 32'h33);
        cyc(0, 0, '0, 1, 0);

        // streaming with cycling selector
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            cyc(1, 2'(i % 4), d, 1, 0);
            check("stream_data", b4.MUX_Output, d[(i % 4)*32 +: 32]);
            check("stream_ready", 32'(b4.In_Ready), 32'h1);
        end
        cyc(0, 0, '0, 1, 0);

        // out-of-range selector on the 3-input instance
        cyc(1, 2'd3, rep(32'hCAFE0001), 1, 0);
        check("oor_n3_data", b3.MUX_Output, 32'h0);
        check("oor_n3_valid", 32'(b3.Out_Valid), 32'h1);
        check("oor_n3_err", 32'(b3.Sel_Error), 32'h1);
        check("oor_n4_data", b4.MUX_Output, 32'hCAFE0001);
        check("oor_n4_err", 32'(b4.Sel_Error), 32'h0);

        // flush with both entries full and a simultaneous request
        cyc(1, 1, rep(32'hA1), 0, 0);
        cyc(1, 1, rep(32'hA2), 0, 0);
        check("fl_full", 32'(b4.In_Ready), 32'h0);
        cyc(1, 1, rep(32'hA3), 0, 1);
        check("fl_valid", 32'(b4.Out_Valid), 32'h0);
        check("fl_data", b4.MUX_Output, 32'h0);
        check("fl_ready", 32'(b4.In_Ready), 32'h1);
        check("fl_err_sticky", 32'(b3.Sel_Error), 32'h1);
        cyc(1, 1, rep(32'hA4), 1, 1);
        cyc(0, 0, '0, 1, 0);
        check("fl_dropped", 32'(b4.Out_Valid), 32'h0);

        // async reset while full
        cyc(1, 0, rep(32'hB1), 0, 0);
        cyc(1, 0, rep(32'hB2), 0, 0);
        #3 reset = 1'b0;
        #1;
        model_reset();
        cmp_all();
        check("ar_valid", 32'(b4.Out_Valid), 32'h0);
        check("ar_data", b4.MUX_Output, 32'h0);
        check("ar_err", 32'(b3.Sel_Error), 32'h0);
        @(posedge clk);
        #2 reset = 1'b1;
        cyc(1, 2'd2, rep(32'h55), 1, 0);
        check("ar_resume", b4.MUX_Output, 32'h55);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d,
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
